// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer and its priority encoder.
package irq_pkg;

    localparam int NUM_IRQ  = 32;
    localparam int IRQ_ID_W = 5;

    localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VECTOR_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Handler address; 32-bit wrap-around is intentional.
    function automatic logic [31:0] vector_addr(input logic [31:0]         base,
                                                input logic [31:0]         stride,
                                                input logic [IRQ_ID_W-1:0] id);
        return base + {{(32-IRQ_ID_W){1'b0}}, id} * stride;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_priority_encoder
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0]  eligible,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] idx
);

    always_comb begin
        valid = |eligible;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) idx = IRQ_ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_priority_sequencer.sv
// Captures interrupt edges, masks them and delivers the lowest-index eligible source
// to the core through a request / ack / end-of-interrupt handshake.
module irq_priority_sequencer
    import irq_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [31:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_req,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    output logic [NUM_IRQ-1:0]  irq_mask,
    output logic [NUM_IRQ-1:0]  irq_pending,
    output logic                cpu_irq,
    output logic [IRQ_ID_W-1:0] cpu_irq_id,
    output logic [31:0]         cpu_vector,
    input  logic                cpu_ack,
    input  logic                cpu_eoi,
    output logic                in_service
);

    irq_state_e          state_q, state_d;
    logic [NUM_IRQ-1:0]  irq_req_q, irq_req_d;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  mask_q, mask_d;
    logic [IRQ_ID_W-1:0] id_q, id_d;
    logic [31:0]         vector_q, vector_d;

    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  pend_clr;
    logic                win_valid;
    logic [IRQ_ID_W-1:0] win_idx;
    logic                take_ack;

    assign eligible = pending_q & ~mask_q;
    assign take_ack = (state_q == REQUEST) && cpu_ack;

    irq_priority_encoder u_prio (
        .eligible (eligible),
        .valid    (win_valid),
        .idx      (win_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = REQUEST;
            REQUEST: if (cpu_ack)   state_d = SERVICE;
            SERVICE: if (cpu_eoi)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_irq    = (state_q == REQUEST);
        in_service = (state_q == SERVICE);
    end

    // Clear on ack and set on a new edge in the same cycle: the set must win.
    always_comb begin
        irq_req_d = irq_req;
        mask_d    = mask_we ? mask_wdata : mask_q;
        pend_clr  = take_ack ? (NUM_IRQ'(1) << id_q) : '0;
        pending_d = (pending_q & ~pend_clr) | (irq_req & ~irq_req_q);
        id_d      = id_q;
        vector_d  = vector_q;
        if (state_q == IDLE && win_valid) begin
            id_d     = win_idx;
            vector_d = vector_addr(VECTOR_BASE, VECTOR_STRIDE, win_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_req_q <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            vector_q  <= VECTOR_BASE;
        end else begin
            irq_req_q <= irq_req_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            vector_q  <= vector_d;
        end
    end

    assign irq_mask    = mask_q;
    assign irq_pending = pending_q;
    assign cpu_irq_id  = id_q;
    assign cpu_vector  = vector_q;

endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Directed bench for irq_priority_sequencer with a cycle-level reference model.
module tb_irq_priority_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] irq_req = '0;
    logic        mask_we = 1'b0;
    logic [31:0] mask_wdata = '0;
    logic [31:0] irq_mask, irq_pending;
    logic        cpu_irq;
    logic [4:0]  cpu_irq_id;
    logic [31:0] cpu_vector;
    logic        cpu_ack = 1'b0;
    logic        cpu_eoi = 1'b0;
    logic        in_service;

    int n_vec = 0;
    int n_err = 0;

    irq_priority_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .irq_req     (irq_req),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .irq_mask    (irq_mask),
        .irq_pending (irq_pending),
        .cpu_irq     (cpu_irq),
        .cpu_irq_id  (cpu_irq_id),
        .cpu_vector  (cpu_vector),
        .cpu_ack     (cpu_ack),
        .cpu_eoi     (cpu_eoi),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = nothing outstanding, 1 = awaiting ack, 2 = handler running.
    logic [31:0] m_prev, m_pend, m_mask, m_next_pend, m_elig;
    int          m_phase, m_id;

    function automatic int lowest_set(input logic [31:0] v);
        int k = 0;
        while (k < 32 && !v[k]) k++;
        return k;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev = '0; m_pend = '0; m_mask = '0; m_phase = 0; m_id = 0;
        end else begin
            m_next_pend = m_pend;
            if (m_phase == 1 && cpu_ack) m_next_pend[m_id] = 1'b0;
            m_next_pend = m_next_pend | (irq_req & ~m_prev);
            m_elig = m_pend & ~m_mask;
            if (m_phase == 0) begin
                if (m_elig != 0) begin
                    m_id = lowest_set(m_elig);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (cpu_ack) m_phase = 2;
            end else if (cpu_eoi) begin
                m_phase = 0;
            end
            m_prev = irq_req;
            if (mask_we) m_mask = mask_wdata;
            m_pend = m_next_pend;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset the DUT must agree with the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("model pending", irq_pending, m_pend);
            chk("model mask", irq_mask, m_mask);
            chk("model cpu_irq", {31'b0, cpu_irq}, {31'b0, m_phase == 1});
            chk("model in_service", {31'b0, in_service}, {31'b0, m_phase == 2});
            chk("model id", {27'b0, cpu_irq_id}, m_id);
            chk("model vector", cpu_vector, 32'h100 + m_id * 4);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("reset cpu_irq", {31'b0, cpu_irq}, 32'd0);
        chk("reset vector", cpu_vector, 32'h100);
        chk("reset pending", irq_pending, 32'd0);
        reset = 1'b0;
        cyc(1);

        // single source 5
        irq_req = 32'h20;
        cyc(1);
        chk("s5 pending", irq_pending, 32'h20);
        chk("s5 no irq yet", {31'b0, cpu_irq}, 32'd0);
        irq_req = 0;
        cyc(1);
        chk("s5 cpu_irq", {31'b0, cpu_irq}, 32'd1);
        chk("s5 id", {27'b0, cpu_irq_id}, 32'd5);
        chk("s5 vector", cpu_vector, 32'h114);
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        chk("s5 pend clr", irq_pending, 32'd0);
        chk("s5 in_service", {31'b0, in_service}, 32'd1);
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        chk("s5 eoi", {31'b0, in_service}, 32'd0);
        cyc(2);

        // priority 3 vs 9
        irq_req = 32'h208; cyc(1); irq_req = 0; cyc(1);
        chk("prio id3", {27'b0, cpu_irq_id}, 32'd3);
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        chk("prio gap", {31'b0, cpu_irq}, 32'd0);
        cyc(1);
        chk("prio id9", {27'b0, cpu_irq_id}, 32'd9);
        chk("prio vec9", cpu_vector, 32'h124);
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        cyc(1);

        // mask bit 7
        mask_we = 1; mask_wdata = 32'h80; cyc(1); mask_we = 0;
        irq_req = 32'h80; cyc(1); irq_req = 0; cyc(2);
        chk("mask no irq", {31'b0, cpu_irq}, 32'd0);
        chk("mask pending7", irq_pending, 32'h80);
        mask_we = 1; mask_wdata = 0; cyc(1); mask_we = 0;
        chk("unmask 1 edge", {31'b0, cpu_irq}, 32'd0);
        cyc(1);
        chk("unmask irq", {31'b0, cpu_irq}, 32'd1);
        chk("unmask id7", {27'b0, cpu_irq_id}, 32'd7);
        // masking the committed source keeps the request up
        mask_we = 1; mask_wdata = 32'h80; cyc(1); mask_we = 0;
        chk("committed", {31'b0, cpu_irq}, 32'd1);
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        mask_we = 1; mask_wdata = 0; cyc(1); mask_we = 0;
        cyc(1);

        // set wins over ack-clear on source 2
        irq_req = 32'h4; cyc(1); irq_req = 0; cyc(1);
        chk("sw id2", {27'b0, cpu_irq_id}, 32'd2);
        irq_req = 32'h4; cpu_ack = 1; cyc(1); cpu_ack = 0; irq_req = 0;
        chk("sw pend2", irq_pending, 32'h4);
        cpu_eoi = 1; cyc(1); cpu_eoi = 0; cyc(1);
        chk("sw rereq", {31'b0, cpu_irq}, 32'd1);
        chk("sw rereq id", {27'b0, cpu_irq_id}, 32'd2);
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        cyc(1);

        // stray handshakes
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        chk("stray ack", {31'b0, in_service}, 32'd0);
        irq_req = 32'h1; cyc(1); irq_req = 0; cyc(1);
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        chk("stray eoi", {31'b0, cpu_irq}, 32'd1);
        chk("stray eoi id0", {27'b0, cpu_irq_id}, 32'd0);
        cpu_ack = 1; cyc(1); cpu_ack = 0;
        cpu_eoi = 1; cyc(1); cpu_eoi = 0;
        cyc(1);

        // reset in SERVICE with 0xF00 pending
        irq_req = 32'h2; cyc(1); cyc(1);
        chk("rst id1", {27'b0, cpu_irq_id}, 32'd1);
        irq_req = 32'hF02; cpu_ack = 1; cyc(1); cpu_ack = 0;
        chk("rst pend", irq_pending, 32'hF00);
        chk("rst svc", {31'b0, in_service}, 32'd1);
        #2 reset = 1; irq_req = 0;
        #1;
        chk("async svc", {31'b0, in_service}, 32'd0);
        chk("async pend", irq_pending, 32'd0);
        chk("async vec", cpu_vector, 32'h100);
        chk("async mask", irq_mask, 32'd0);
        cyc(1);
        reset = 0;
        cyc(3);
        chk("post rst irq", {31'b0, cpu_irq}, 32'd0);
        chk("post rst pend", irq_pending, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_priority_sequencer.md
# irq_priority_sequencer

Sequences delivery of 32 interrupt sources to the CPU core one at a time. It captures rising edges into a pending register and applies a software-writable mask. It selects the highest-priority eligible source and runs a request/acknowledge/end-of-interrupt handshake with the core. It sits between peripheral interrupt lines and the core's exception entry logic, and supplies the handler vector address.

## Interface
- NUM_IRQ, 32: number of interrupt sources; fixed at 32 for this design.
- VECTOR_BASE, 32'h0000_0100: address of the vector for source 0.
- VECTOR_STRIDE, 4: byte distance between consecutive vectors.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- irq_req  in  32  raw interrupt lines from peripherals, synchronous to clk
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  32  new mask value; bit=1 blocks that source
- irq_mask  out  32  current mask register
- irq_pending  out  32  current pending register
- cpu_irq  out  1  interrupt request to the core
- cpu_irq_id  out  5  index of the requested source
- cpu_vector  out  32  handler address for cpu_irq_id
- cpu_ack  in  1  core accepts the request
- cpu_eoi  in  1  core signals end of handler
- in_service  out  1  high while a handler is active

## Operation
- Edge capture: irq_req_q registers irq_req. Pending bit i sets on any edge where irq_req[i]=1 and irq_req_q[i]=0.
- Eligible = pending & ~mask. Priority is fixed: the lowest index wins.
- FSM states:
  - IDLE: if eligible != 0, latch the winner id and go to REQUEST.
  - REQUEST: cpu_irq=1. id and vector stay stable until cpu_ack. On cpu_ack, clear pending[id] and go to SERVICE.
  - SERVICE: in_service=1. On cpu_eoi, go to IDLE.
- There is no nesting. A new or higher-priority edge during REQUEST or SERVICE stays pending and is arbitrated only on return to IDLE.
- cpu_vector = VECTOR_BASE + id*VECTOR_STRIDE, computed in 32-bit arithmetic; wrap-around is permitted.
- Mask writes take effect on the next edge. Masking the latched source during REQUEST does not withdraw the request: the request is committed.
- A set and a clear hitting the same pending bit on one edge (new edge arriving with the ack) resolve as set wins.
- cpu_ack outside REQUEST is ignored. cpu_eoi outside SERVICE is ignored.
- Pending bits for masked sources keep accumulating. Unmasking them makes them eligible.

## Timing
- Reset values: irq_mask=0, irq_pending=0, irq_req_q=0, state=IDLE, cpu_irq=0, cpu_irq_id=0, cpu_vector=VECTOR_BASE, in_service=0.
- Reset is asynchronous. Asserting it mid-handshake drops cpu_irq and in_service immediately and discards all pending bits.
- Request latency:
  - irq_req[i] first sampled high at edge N sets pending[i] after N.
  - If the FSM is IDLE and i wins, cpu_irq, id and vector are valid after edge N+1.
- Handshake:
  - cpu_ack sampled at edge M: cpu_irq=0 and in_service=1 after M.
  - cpu_eoi sampled at edge K: in_service=0 after K.
  - The earliest next cpu_irq is after edge K+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package irq_pkg holds:
  - NUM_IRQ and IRQ_ID_W=5
  - the FSM state enum (IDLE, REQUEST, SERVICE)
  - the default VECTOR_BASE and VECTOR_STRIDE constants
- One sub-module, irq_priority_encoder: combinational, 32-bit eligible vector in, valid + 5-bit lowest-set index out. It is reused by later multi-core dispatch logic.

## Test plan
- Single source: pulse irq_req[5] at edge N -> cpu_irq=1, cpu_irq_id=5, cpu_vector=32'h114 after N+1. Ack -> pending[5]=0 and in_service=1. EOI -> idle.
- Priority: bits 3 and 9 rise together -> id=3 served first. After EOI, id=9 is requested at K+1 with vector 32'h124.
- Mask:
  - Mask bit 7, then pulse it -> no cpu_irq, pending[7]=1.
  - Unmask -> cpu_irq with id=7 two edges after the mask write.
- Set-wins collision: a rising edge on source 2 on the same edge as cpu_ack for id=2 -> pending[2] remains 1, and it is re-requested after EOI.
- Stray handshakes: cpu_ack in IDLE and cpu_eoi in REQUEST -> state unchanged and cpu_irq held.
- Reset mid-SERVICE with pending=32'h0000_0F00 -> all outputs at reset values within the same cycle, and no request after release.
